// File: rtl/pkg_arb.sv
// Arbiter FSM states, requester identifiers and latency counter width.
package pkg_arb;
  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {ARB_IDLE, ARB_ISSUE, ARB_WAIT, ARB_DONE} state_t;
  typedef enum logic [1:0] {ARB_NONE, ARB_LDR, ARB_CU, ARB_DAT} master_t;
endpackage

// File: rtl/pkg_ram.sv
// RAM device access types shared by the RAM device and its requesters.
package pkg_ram;
  localparam int RAM_ADDRW = 16;

  typedef enum logic [1:0] {RAM_NOP, RAM_FETCH, RAM_STORE} op_t;
  typedef enum logic [1:0] {RAM_SZ_B, RAM_SZ_H, RAM_SZ_W, RAM_SZ_D} size_t;
endpackage

// File: rtl/arb_pick.sv
// Winner select: loader has fixed priority, CU/DAT alternate when both request.
module arb_pick
  import pkg_arb::*;
(
  input  logic    ldr_req_i,
  input  logic    cu_req_i,
  input  logic    dat_req_i,
  input  master_t rr_last_i,
  output master_t winner_o
);

  always_comb begin
    winner_o = ARB_NONE;
    if (ldr_req_i) begin
      winner_o = ARB_LDR;
    end else if (cu_req_i && dat_req_i) begin
      winner_o = (rr_last_i == ARB_CU) ? ARB_DAT : ARB_CU;
    end else if (cu_req_i) begin
      winner_o = ARB_CU;
    end else if (dat_req_i) begin
      winner_o = ARB_DAT;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one RAM device between loader, CU fetch and data bus via req/ack,
// registering the winning request and timing the RAM read latency.
module ram_arbiter
  import pkg_ram::*;
  import pkg_arb::*;
#(
  parameter int ADDR_W  = RAM_ADDRW,
  parameter int DATA_W  = 64,
  parameter int RAM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ldr_req,
  input  op_t               ldr_op,
  input  size_t             ldr_size,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,
  input  logic              cu_req,
  input  op_t               cu_op,
  input  size_t             cu_size,
  input  logic [ADDR_W-1:0] cu_addr,
  input  logic [DATA_W-1:0] cu_wdata,
  output logic              cu_gnt,
  output logic              cu_ack,
  output logic [DATA_W-1:0] cu_rdata,
  input  logic              dat_req,
  input  op_t               dat_op,
  input  size_t             dat_size,
  input  logic [ADDR_W-1:0] dat_addr,
  input  logic [DATA_W-1:0] dat_wdata,
  output logic              dat_gnt,
  output logic              dat_ack,
  output logic [DATA_W-1:0] dat_rdata,
  output op_t               ram_op,
  output size_t             ram_size,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic              busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(RAM_LAT - 1);
  localparam logic [LAT_CNT_W-1:0] LAT_ONE  = LAT_CNT_W'(1);

  state_t                state_q, state_d;
  master_t               owner_q, owner_d, rr_last_q, rr_last_d, winner;
  op_t                   op_q, op_d;
  size_t                 size_q, size_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [LAT_CNT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0]     ldr_rdata_q, ldr_rdata_d;
  logic [DATA_W-1:0]     cu_rdata_q, cu_rdata_d;
  logic [DATA_W-1:0]     dat_rdata_q, dat_rdata_d;

  arb_pick u_pick (
    .ldr_req_i (ldr_req),
    .cu_req_i  (cu_req),
    .dat_req_i (dat_req),
    .rr_last_i (rr_last_q),
    .winner_o  (winner)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      owner_q     <= ARB_NONE;
      rr_last_q   <= ARB_DAT;
      op_q        <= RAM_NOP;
      size_q      <= RAM_SZ_B;
      addr_q      <= '0;
      wdata_q     <= '0;
      lat_cnt_q   <= '0;
      ldr_rdata_q <= '0;
      cu_rdata_q  <= '0;
      dat_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_last_q   <= rr_last_d;
      op_q        <= op_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lat_cnt_q   <= lat_cnt_d;
      ldr_rdata_q <= ldr_rdata_d;
      cu_rdata_q  <= cu_rdata_d;
      dat_rdata_q <= dat_rdata_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_last_d   = rr_last_q;
    op_d        = op_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    lat_cnt_d   = lat_cnt_q;
    ldr_rdata_d = ldr_rdata_q;
    cu_rdata_d  = cu_rdata_q;
    dat_rdata_d = dat_rdata_q;
    ram_op      = RAM_NOP;
    ldr_ack     = 1'b0;
    cu_ack      = 1'b0;
    dat_ack     = 1'b0;

    case (state_q)
      ARB_IDLE: begin
        case (winner)
          ARB_LDR: begin
            op_d = ldr_op; size_d = ldr_size; addr_d = ldr_addr; wdata_d = ldr_wdata;
          end
          ARB_CU: begin
            op_d = cu_op; size_d = cu_size; addr_d = cu_addr; wdata_d = cu_wdata;
          end
          ARB_DAT: begin
            op_d = dat_op; size_d = dat_size; addr_d = dat_addr; wdata_d = dat_wdata;
          end
          default: ;
        endcase
        if (winner != ARB_NONE) begin
          owner_d = winner;
          state_d = ARB_ISSUE;
        end
      end
      ARB_ISSUE: begin
        ram_op    = op_q;
        lat_cnt_d = LAT_INIT;
        state_d   = (RAM_LAT > 1) ? ARB_WAIT : ARB_DONE;
      end
      ARB_WAIT: begin
        lat_cnt_d = lat_cnt_q - LAT_ONE;
        if (lat_cnt_q == LAT_ONE) state_d = ARB_DONE;
      end
      ARB_DONE: begin
        // RAM data_out is valid only in this cycle; capture it for the owner.
        case (owner_q)
          ARB_LDR: begin
            ldr_ack = 1'b1;
            if (op_q == RAM_FETCH) ldr_rdata_d = ram_rdata;
          end
          ARB_CU: begin
            cu_ack = 1'b1;
            if (op_q == RAM_FETCH) cu_rdata_d = ram_rdata;
          end
          ARB_DAT: begin
            dat_ack = 1'b1;
            if (op_q == RAM_FETCH) dat_rdata_d = ram_rdata;
          end
          default: ;
        endcase
        if (owner_q == ARB_CU || owner_q == ARB_DAT) rr_last_d = owner_q;
        state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  assign busy      = (state_q != ARB_IDLE);
  assign ldr_gnt   = busy && (owner_q == ARB_LDR);
  assign cu_gnt    = busy && (owner_q == ARB_CU);
  assign dat_gnt   = busy && (owner_q == ARB_DAT);
  assign ram_size  = size_q;
  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ldr_rdata = ldr_rdata_q;
  assign cu_rdata  = cu_rdata_q;
  assign dat_rdata = dat_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with RAM_LAT=1 and RAM_LAT=3 instances and
// behavioural RAMs that present read data only in the exact latency cycle.
module tb_ram_arbiter;
  import pkg_ram::*;

  localparam int AW = RAM_ADDRW;
  localparam int DW = 64;
  localparam logic [DW-1:0] GARBAGE = 64'hBAD0_BAD0_BAD0_BAD0;

  logic clk = 1'b0;
  logic rst1_n, rst3_n;
  always #5 clk = ~clk;

  // instance with RAM_LAT=1
  logic l_req, c_req, d_req;
  op_t l_op, c_op, d_op;
  logic [AW-1:0] l_addr, c_addr, d_addr;
  logic [DW-1:0] l_wd, c_wd, d_wd;
  logic l_gnt, c_gnt, d_gnt, l_ack, c_ack, d_ack;
  logic [DW-1:0] l_rd, c_rd, d_rd;
  op_t r1_op; size_t r1_size;
  logic [AW-1:0] r1_addr;
  logic [DW-1:0] r1_wd, r1_rd;
  logic busy1;

  // instance with RAM_LAT=3, driven from the data port only
  logic x_req;
  op_t x_op;
  logic [AW-1:0] x_addr;
  logic [DW-1:0] x_wd;
  logic x_lgnt, x_cgnt, x_gnt, x_lack, x_cack, x_ack;
  logic [DW-1:0] x_lrd, x_crd, x_rd;
  op_t r3_op; size_t r3_size;
  logic [AW-1:0] r3_addr;
  logic [DW-1:0] r3_wd, r3_rd;
  logic busy3;

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(1)) u_dut1 (
    .clk(clk), .rst_n(rst1_n),
    .ldr_req(l_req), .ldr_op(l_op), .ldr_size(RAM_SZ_D), .ldr_addr(l_addr), .ldr_wdata(l_wd),
    .ldr_gnt(l_gnt), .ldr_ack(l_ack), .ldr_rdata(l_rd),
    .cu_req(c_req), .cu_op(c_op), .cu_size(RAM_SZ_D), .cu_addr(c_addr), .cu_wdata(c_wd),
    .cu_gnt(c_gnt), .cu_ack(c_ack), .cu_rdata(c_rd),
    .dat_req(d_req), .dat_op(d_op), .dat_size(RAM_SZ_D), .dat_addr(d_addr), .dat_wdata(d_wd),
    .dat_gnt(d_gnt), .dat_ack(d_ack), .dat_rdata(d_rd),
    .ram_op(r1_op), .ram_size(r1_size), .ram_addr(r1_addr), .ram_wdata(r1_wd),
    .ram_rdata(r1_rd), .busy(busy1)
  );

  ram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RAM_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n),
    .ldr_req(1'b0), .ldr_op(RAM_NOP), .ldr_size(RAM_SZ_D), .ldr_addr('0), .ldr_wdata('0),
    .ldr_gnt(x_lgnt), .ldr_ack(x_lack), .ldr_rdata(x_lrd),
    .cu_req(1'b0), .cu_op(RAM_NOP), .cu_size(RAM_SZ_D), .cu_addr('0), .cu_wdata('0),
    .cu_gnt(x_cgnt), .cu_ack(x_cack), .cu_rdata(x_crd),
    .dat_req(x_req), .dat_op(x_op), .dat_size(RAM_SZ_D), .dat_addr(x_addr), .dat_wdata(x_wd),
    .dat_gnt(x_gnt), .dat_ack(x_ack), .dat_rdata(x_rd),
    .ram_op(r3_op), .ram_size(r3_size), .ram_addr(r3_addr), .ram_wdata(r3_wd),
    .ram_rdata(r3_rd), .busy(busy3)
  );

  // behavioural RAMs: data_out valid exactly RAM_LAT cycles after a FETCH issue
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem3 [256];
  logic          v1 = 1'b0;
  logic [DW-1:0] q1;
  logic [2:0]    v3 = 3'b000;
  logic [DW-1:0] q3 [3];

  always @(posedge clk) begin
    if (r1_op == RAM_STORE) mem1[r1_addr[7:0]] <= r1_wd;
    v1 <= (r1_op == RAM_FETCH);
    q1 <= mem1[r1_addr[7:0]];
    if (r3_op == RAM_STORE) mem3[r3_addr[7:0]] <= r3_wd;
    v3 <= {v3[1:0], r3_op == RAM_FETCH};
    q3[0] <= mem3[r3_addr[7:0]];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign r1_rd = v1 ? q1 : GARBAGE;
  assign r3_rd = v3[2] ? q3[2] : GARBAGE;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    int            port;   // 0=LDR 1=CU 2=DAT
    op_t           op;
    logic [AW-1:0] addr;
    logic [DW-1:0] wd;
    logic [DW-1:0] el, ec, ed;
    int            ef, es;
  } vec_t;

  vec_t vecs [8];

  function automatic logic own_gnt(input int p);
    case (p)
      0: return l_gnt;
      1: return c_gnt;
      default: return d_gnt;
    endcase
  endfunction

  function automatic logic own_ack(input int p);
    case (p)
      0: return l_ack;
      1: return c_ack;
      default: return d_ack;
    endcase
  endfunction

  task automatic drive1(input int p, input logic r, input op_t op,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
    case (p)
      0: begin l_req = r; l_op = op; l_addr = a; l_wd = wd; end
      1: begin c_req = r; c_op = op; c_addr = a; c_wd = wd; end
      default: begin d_req = r; d_op = op; d_addr = a; d_wd = wd; end
    endcase
  endtask

  task automatic run1(input int i);
    vec_t v;
    int lat, g, other, f, s;
    v = vecs[i];
    lat = 0; g = 0; other = 0; f = 0; s = 0;
    drive1(v.port, 1'b1, v.op, v.addr, v.wd);
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (own_gnt(v.port)) g++;
      other += int'(l_gnt) + int'(c_gnt) + int'(d_gnt) - int'(own_gnt(v.port));
      if (r1_op == RAM_FETCH) f++;
      if (r1_op == RAM_STORE) s++;
      if (own_ack(v.port)) begin
        lat = n;
        break;
      end
    end
    drive1(v.port, 1'b0, RAM_NOP, '0, '0);
    tick();
    check($sformatf("v%0d_ack_latency", i), DW'(lat), DW'(2));
    check($sformatf("v%0d_gnt_cycles", i), DW'(g), DW'(2));
    check($sformatf("v%0d_foreign_gnt", i), DW'(other), DW'(0));
    check($sformatf("v%0d_fetch_issues", i), DW'(f), DW'(v.ef));
    check($sformatf("v%0d_store_issues", i), DW'(s), DW'(v.es));
    check($sformatf("v%0d_ram_addr", i), DW'(r1_addr), DW'(v.addr));
    check($sformatf("v%0d_ldr_rdata", i), l_rd, v.el);
    check($sformatf("v%0d_cu_rdata", i), c_rd, v.ec);
    check($sformatf("v%0d_dat_rdata", i), d_rd, v.ed);
    check($sformatf("v%0d_busy_after", i), DW'(busy1), DW'(0));
  endtask

  task automatic run3(input op_t op, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      output int lat, output op_t o1, output op_t o2, output op_t o3,
                      output logic [DW-1:0] rd_at_ack);
    lat = 0; o1 = RAM_NOP; o2 = RAM_NOP; o3 = RAM_NOP; rd_at_ack = '0;
    x_req = 1'b1; x_op = op; x_addr = a; x_wd = wd;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (n == 1) o1 = r3_op;
      if (n == 2) o2 = r3_op;
      if (n == 3) o3 = r3_op;
      if (x_ack) begin
        lat = n;
        rd_at_ack = x_rd;
        break;
      end
    end
    x_req = 1'b0; x_op = RAM_NOP;
    tick();
  endtask

  localparam logic [DW-1:0] BEEF = 64'h0000_0000_DEAD_BEEF;
  localparam logic [DW-1:0] PAT  = 64'h1234_5678_9ABC_DEF0;
  localparam logic [DW-1:0] CAFE = 64'hCAFE_F00D_1234_5678;

  initial begin
    int lat, nl, nc, overlap, nacks, noack;
    int ack_n [4];
    int ack_p [4];
    op_t o1, o2, o3;
    logic [DW-1:0] rda;

    vecs[0] = '{0, RAM_STORE, 16'h0010, BEEF, '0,   '0,   '0,  0, 1};
    vecs[1] = '{1, RAM_FETCH, 16'h0010, '0,   '0,   BEEF, '0,  1, 0};
    vecs[2] = '{2, RAM_STORE, 16'h0018, PAT,  '0,   BEEF, '0,  0, 1};
    vecs[3] = '{2, RAM_FETCH, 16'h0018, '0,   '0,   BEEF, PAT, 1, 0};
    vecs[4] = '{1, RAM_NOP,   16'h0018, '0,   '0,   BEEF, PAT, 0, 0};
    vecs[5] = '{0, RAM_FETCH, 16'h0010, '0,   BEEF, BEEF, PAT, 1, 0};
    vecs[6] = '{1, RAM_STORE, 16'h0010, '0,   BEEF, BEEF, PAT, 0, 1};
    vecs[7] = '{2, RAM_FETCH, 16'h0010, '0,   BEEF, BEEF, '0,  1, 0};

    rst1_n = 1'b0; rst3_n = 1'b0;
    l_req = 0; c_req = 0; d_req = 0; x_req = 0;
    l_op = RAM_NOP; c_op = RAM_NOP; d_op = RAM_NOP; x_op = RAM_NOP;
    l_addr = '0; c_addr = '0; d_addr = '0; x_addr = '0;
    l_wd = '0; c_wd = '0; d_wd = '0; x_wd = '0;

    #12;
    check("rst_gnts", DW'({l_gnt, c_gnt, d_gnt}), DW'(0));
    check("rst_acks", DW'({l_ack, c_ack, d_ack}), DW'(0));
    check("rst_rdata", l_rd | c_rd | d_rd, '0);
    check("rst_ram_op", DW'(r1_op), DW'(RAM_NOP));
    check("rst_ram_fields", DW'(r1_addr) | r1_wd | DW'(r1_size), '0);
    check("rst_busy", DW'(busy1), DW'(0));
    #10;
    rst1_n = 1'b1; rst3_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) run1(i);

    // CU and DAT contend continuously: expect CU, DAT, CU, DAT every RAM_LAT+2
    drive1(1, 1'b1, RAM_FETCH, 16'h0018, '0);
    drive1(2, 1'b1, RAM_FETCH, 16'h0010, '0);
    overlap = 0; nacks = 0;
    for (int k = 0; k < 4; k++) begin ack_n[k] = 0; ack_p[k] = 0; end
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (int'(l_gnt) + int'(c_gnt) + int'(d_gnt) > 1) overlap++;
      if (c_ack && d_ack) overlap++;
      if ((c_ack || d_ack) && nacks < 4) begin
        ack_n[nacks] = n;
        ack_p[nacks] = c_ack ? 1 : 2;
        nacks++;
      end
      if (nacks == 4) break;
    end
    drive1(1, 1'b0, RAM_NOP, '0, '0);
    drive1(2, 1'b0, RAM_NOP, '0, '0);
    tick();
    check("rr_overlap", DW'(overlap), DW'(0));
    for (int k = 0; k < 4; k++) begin
      check($sformatf("rr_owner%0d", k), DW'(ack_p[k]), DW'((k % 2 == 0) ? 1 : 2));
      check($sformatf("rr_ack_cycle%0d", k), DW'(ack_n[k]), DW'(2 + 3 * k));
    end
    check("rr_cu_rdata", c_rd, PAT);
    check("rr_dat_rdata", d_rd, '0);

    // loader STORE beats a pending CU FETCH of the same address
    drive1(0, 1'b1, RAM_STORE, 16'h0020, 64'h55);
    drive1(1, 1'b1, RAM_FETCH, 16'h0020, '0);
    nl = 0; nc = 0; overlap = 0;
    for (int n = 1; n <= 30; n++) begin
      tick();
      if (int'(l_gnt) + int'(c_gnt) + int'(d_gnt) > 1) overlap++;
      if (l_ack) begin nl = n; drive1(0, 1'b0, RAM_NOP, '0, '0); end
      if (c_ack) begin nc = n; drive1(1, 1'b0, RAM_NOP, '0, '0); break; end
    end
    drive1(0, 1'b0, RAM_NOP, '0, '0);
    drive1(1, 1'b0, RAM_NOP, '0, '0);
    tick();
    check("prio_ldr_ack", DW'(nl), DW'(2));
    check("prio_cu_ack", DW'(nc), DW'(5));
    check("prio_overlap", DW'(overlap), DW'(0));
    check("prio_cu_rdata", c_rd, 64'h55);
    check("prio_dat_rdata", d_rd, '0);
    check("prio_ldr_rdata", l_rd, BEEF);

    // RAM_LAT=3: store then fetch, data captured only on the DONE cycle
    run3(RAM_STORE, 16'h0008, CAFE, lat, o1, o2, o3, rda);
    check("lat3_store_ack", DW'(lat), DW'(4));
    check("lat3_store_op", DW'(o1), DW'(RAM_STORE));
    run3(RAM_FETCH, 16'h0008, '0, lat, o1, o2, o3, rda);
    check("lat3_fetch_ack", DW'(lat), DW'(4));
    check("lat3_op_issue", DW'(o1), DW'(RAM_FETCH));
    check("lat3_op_wait1", DW'(o2), DW'(RAM_NOP));
    check("lat3_op_wait2", DW'(o3), DW'(RAM_NOP));
    check("lat3_rdata_at_ack", rda, '0);
    check("lat3_rdata_after", x_rd, CAFE);
    check("lat3_unused_ports", DW'({x_lgnt, x_cgnt, x_lack, x_cack}) | x_lrd | x_crd, '0);

    // async reset while in WAIT drops the transaction; held req then completes
    x_req = 1'b1; x_op = RAM_FETCH; x_addr = 16'h0008; x_wd = '0;
    tick();
    tick();
    check("rstw_busy_before", DW'(busy3), DW'(1));
    #1 rst3_n = 1'b0;
    #1;
    check("rstw_gnt", DW'(x_gnt), DW'(0));
    check("rstw_busy", DW'(busy3), DW'(0));
    check("rstw_rdata", x_rd, '0);
    check("rstw_ram_fields", DW'(r3_op) | DW'(r3_addr), '0);
    noack = 0;
    for (int n = 0; n < 2; n++) begin
      tick();
      if (x_ack) noack++;
    end
    rst3_n = 1'b1;
    check("rstw_no_ack", DW'(noack), DW'(0));
    check("rstw_idle_after", DW'(busy3), DW'(0));
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (x_ack) begin lat = n; break; end
    end
    x_req = 1'b0; x_op = RAM_NOP;
    tick();
    check("rstw_reissue_ack", DW'(lat), DW'(4));
    check("rstw_reissue_rdata", x_rd, CAFE);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
